pixel_scheduler: RTL and testbench

PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

---
 rtl/pixel_scheduler_pkg.sv | 24 ++
 rtl/pixel_scheduler_if.sv | 30 +++
 rtl/pixel_scheduler_scan_counter.sv | 50 +++++
 rtl/pixel_scheduler.sv | 112 +++++++++++
 tb/tb_pixel_scheduler.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_scheduler_pkg.sv
// Shared raster defaults and scheduler state encoding, common to the scheduler,
// the point generator and the frame buffer.
package pixel_scheduler_pkg;

    localparam int H_RES_DEF  = 640;
    localparam int V_RES_DEF  = 480;
    localparam int HBI_DEF    = 32;
    localparam int ADDR_W_DEF = 19;
    localparam int COORD_W    = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_WAIT,
        S_WRITE
    } sched_state_e;

    // True when a frame of h x v pixels can be addressed with w address bits.
    function automatic bit frame_fits(int h, int v, int w);
        return (longint'(h) * longint'(v)) <= (longint'(1) << w);
    endfunction

endpackage

// File: rtl/pixel_scheduler_if.sv
// Point-generator handshake plus frame-buffer write port, seen from the
// scheduler (master) and from the generator/buffer side (slave).
interface pixel_scheduler_if
    import pixel_scheduler_pkg::*;
#(
    parameter int HBI    = HBI_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic               pg_start;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               pg_ready;
    logic [HBI-1:0]     pg_iteration;

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [HBI-1:0]     wr_data;

    modport master (
        output pg_start, x, y, wr_en, wr_addr, wr_data,
        input  pg_ready, pg_iteration
    );

    modport slave (
        input  pg_start, x, y, wr_en, wr_addr, wr_data,
        output pg_ready, pg_iteration
    );

endinterface

// File: rtl/pixel_scheduler_scan_counter.sv
// Raster scan position: column, row and a running linear frame-buffer address,
// so the address never needs a y*H_RES multiply.
module scan_counter
    import pixel_scheduler_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               last
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

    logic x_at_end;

    assign x_at_end = (x == X_MAX);
    assign last     = x_at_end && (y == Y_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            addr <= addr + ADDR_W'(1);
            if (x_at_end) begin
                x <= '0;
                y <= y + COORD_W'(1);
            end else begin
                x <= x + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_scheduler.sv
// Walks every pixel of a frame: launches the point generator, waits for its
// result and writes the iteration count to the frame buffer.
module pixel_scheduler
    import pixel_scheduler_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int HBI    = HBI_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                frame_start,
    input  logic                abort,
    output logic                busy,
    output logic                frame_done,
    pixel_scheduler_if.master   bus
);

    sched_state_e   state;
    logic [HBI-1:0] wr_data_q;
    logic           pg_start_q;
    logic           wr_en_q;
    logic           clear;
    logic           advance;
    logic           last;

    // Counters only move on a real frame start or a completed non-final write;
    // abort freezes them where they are.
    assign clear   = (state == S_IDLE) && frame_start && !abort;
    assign advance = (state == S_WRITE) && !abort && !last;

    scan_counter #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clear   (clear),
        .advance (advance),
        .x       (bus.x),
        .y       (bus.y),
        .addr    (bus.wr_addr),
        .last    (last)
    );

    assign bus.pg_start = pg_start_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_data  = wr_data_q;

    // Strobes are set on the edge that enters their state, so each one is a
    // flop output that stays high for exactly that state's single cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            pg_start_q <= 1'b0;
            wr_en_q    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            pg_start_q <= 1'b0;
            wr_en_q    <= 1'b0;
            frame_done <= 1'b0;

            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (frame_start) begin
                            state      <= S_LAUNCH;
                            pg_start_q <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                    S_LAUNCH: begin
                        state <= S_SETTLE;
                    end
                    // pg_ready still reflects the previous pixel here.
                    S_SETTLE: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (bus.pg_ready) begin
                            wr_data_q <= bus.pg_iteration;
                            wr_en_q   <= 1'b1;
                            state     <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        if (last) begin
                            state      <= S_IDLE;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            state      <= S_LAUNCH;
                            pg_start_q <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler on a 4x3 raster with a behavioural
// point generator whose latency and stale-ready behaviour are selectable.
module tb_pixel_scheduler;
    import pixel_scheduler_pkg::*;

    localparam int TB_H   = 4;
    localparam int TB_V   = 3;
    localparam int TB_HBI = 32;
    localparam int TB_AW  = 19;

    logic CLK = 1'b0;
    logic RST_N;
    logic frame_start;
    logic abort;
    logic busy;
    logic frame_done;

    pixel_scheduler_if #(.HBI(TB_HBI), .ADDR_W(TB_AW)) bus ();

    pixel_scheduler #(
        .H_RES  (TB_H),
        .V_RES  (TB_V),
        .HBI    (TB_HBI),
        .ADDR_W (TB_AW)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .frame_start (frame_start),
        .abort       (abort),
        .busy        (busy),
        .frame_done  (frame_done),
        .bus         (bus)
    );

    always #5 CLK = ~CLK;

    // ---------------- point generator model ----------------
    int         n_lat = 1;
    bit         stale_mode = 1'b0;
    logic       start_d;
    int         cnt;
    logic [11:0] px, py;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.pg_ready     <= 1'b1;
            bus.pg_iteration <= '0;
            start_d          <= 1'b0;
            cnt              <= 0;
            px               <= '0;
            py               <= '0;
        end else begin
            start_d <= bus.pg_start;
            if (stale_mode ? start_d : bus.pg_start) begin
                cnt          <= stale_mode ? n_lat - 1 : n_lat;
                bus.pg_ready <= 1'b0;
                px           <= bus.x;
                py           <= bus.y;
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    bus.pg_ready     <= 1'b1;
                    bus.pg_iteration <= 32'(int'(px) + 10 * int'(py));
                end
            end
        end
    end

    // ---------------- monitor ----------------
    typedef struct {
        logic [TB_AW-1:0] addr;
        logic [11:0]      x;
        logic [11:0]      y;
        logic [31:0]      data;
        int               cyc;
    } wr_rec_t;

    int      cyc = 0;
    wr_rec_t w_q[$];
    int      ps_q[$];
    int      fd_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.wr_en)
            w_q.push_back('{bus.wr_addr, bus.x, bus.y, bus.wr_data, cyc});
        if (bus.pg_start) ps_q.push_back(cyc);
        if (frame_done)   fd_q.push_back(cyc);
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".busy"},       64'(busy),         64'd0);
        check({tag, ".pg_start"},   64'(bus.pg_start), 64'd0);
        check({tag, ".wr_en"},      64'(bus.wr_en),    64'd0);
        check({tag, ".frame_done"}, 64'(frame_done),   64'd0);
        check({tag, ".x"},          64'(bus.x),        64'd0);
        check({tag, ".y"},          64'(bus.y),        64'd0);
        check({tag, ".wr_addr"},    64'(bus.wr_addr),  64'd0);
        check({tag, ".wr_data"},    64'(bus.wr_data),  64'd0);
    endtask

    task automatic pulse_start();
        @(posedge CLK); #1 frame_start = 1'b1;
        @(posedge CLK); #1 frame_start = 1'b0;
    endtask

    task automatic wait_frame(input int base, input int budget);
        for (int i = 0; i < budget && fd_q.size() <= base; i++) @(negedge CLK);
        check("frame_done_seen", 64'(fd_q.size() > base), 64'd1);
    endtask

    task automatic wait_writes(input int target, input int budget);
        for (int i = 0; i < budget && w_q.size() < target; i++) @(negedge CLK);
        check("write_seen", 64'(w_q.size() >= target), 64'd1);
    endtask

    task automatic wait_launches(input int target, input int budget);
        for (int i = 0; i < budget && ps_q.size() < target; i++) @(negedge CLK);
        check("launch_seen", 64'(ps_q.size() >= target), 64'd1);
    endtask

    typedef struct {
        logic [TB_AW-1:0] addr;
        logic [11:0]      x;
        logic [11:0]      y;
        logic [31:0]      data;
        int               dcyc;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int ws, ps, fs;

        // x, y, data = x+10*y, cycles after the first pg_start (4 per pixel, write in 4th)
        tbl[0]  = '{0,  0, 0,  0,  3};
        tbl[1]  = '{1,  1, 0,  1,  7};
        tbl[2]  = '{2,  2, 0,  2, 11};
        tbl[3]  = '{3,  3, 0,  3, 15};
        tbl[4]  = '{4,  0, 1, 10, 19};
        tbl[5]  = '{5,  1, 1, 11, 23};
        tbl[6]  = '{6,  2, 1, 12, 27};
        tbl[7]  = '{7,  3, 1, 13, 31};
        tbl[8]  = '{8,  0, 2, 20, 35};
        tbl[9]  = '{9,  1, 2, 21, 39};
        tbl[10] = '{10, 2, 2, 22, 43};
        tbl[11] = '{11, 3, 2, 23, 47};

        RST_N       = 1'b0;
        frame_start = 1'b0;
        abort       = 1'b0;
        #12;
        check_zero_outputs("reset");
        @(negedge CLK) RST_N = 1'b1;

        // ---- full frame, one-cycle generator ----
        n_lat = 1;
        ws = w_q.size(); ps = ps_q.size(); fs = fd_q.size();
        pulse_start();
        wait_frame(fs, 200);
        repeat (10) @(negedge CLK);
        check("frame1.writes", 64'(w_q.size() - ws), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (ws + i < w_q.size() && ps < ps_q.size()) begin
                check($sformatf("w%0d.addr", i), 64'(w_q[ws+i].addr), 64'(tbl[i].addr));
                check($sformatf("w%0d.x", i),    64'(w_q[ws+i].x),    64'(tbl[i].x));
                check($sformatf("w%0d.y", i),    64'(w_q[ws+i].y),    64'(tbl[i].y));
                check($sformatf("w%0d.data", i), 64'(w_q[ws+i].data), 64'(tbl[i].data));
                check($sformatf("w%0d.cycle", i), 64'(w_q[ws+i].cyc - ps_q[ps]), 64'(tbl[i].dcyc));
            end
        end
        check("frame1.done_count", 64'(fd_q.size() - fs), 64'd1);
        if (fd_q.size() > fs && ps < ps_q.size())
            check("frame1.done_cycle", 64'(fd_q[fs] - ps_q[ps]), 64'd48);
        check("frame1.busy_after", 64'(busy), 64'd0);
        check("frame1.final_x",    64'(bus.x), 64'd3);
        check("frame1.final_y",    64'(bus.y), 64'd2);
        check("frame1.final_addr", 64'(bus.wr_addr), 64'd11);

        // ---- frame_start while busy is ignored ----
        n_lat = 2;
        ws = w_q.size(); fs = fd_q.size();
        pulse_start();
        repeat (10) @(posedge CLK);
        check("busy_mid_frame", 64'(busy), 64'd1);
        pulse_start();
        wait_frame(fs, 300);
        repeat (20) @(negedge CLK);
        check("restart_ignored.writes", 64'(w_q.size() - ws), 64'd12);
        check("restart_ignored.done",   64'(fd_q.size() - fs), 64'd1);

        // ---- stale pg_ready during start/settle, 5 WAIT cycles ----
        n_lat = 5; stale_mode = 1'b1;
        ws = w_q.size(); ps = ps_q.size();
        check("stale.ready_high_before", 64'(bus.pg_ready), 64'd1);
        pulse_start();
        wait_writes(ws + 1, 40);
        if (w_q.size() > ws && ps < ps_q.size()) begin
            check("stale.first_write_cycle", 64'(w_q[ws].cyc - ps_q[ps]), 64'd7);
            check("stale.first_write_addr",  64'(w_q[ws].addr), 64'd0);
        end
        @(posedge CLK); #1 abort = 1'b1;
        @(posedge CLK); #1 abort = 1'b0;
        stale_mode = 1'b0;
        @(negedge CLK);
        check("stale.abort_busy", 64'(busy), 64'd0);

        // ---- abort in WAIT of pixel 5 ----
        n_lat = 3;
        ws = w_q.size(); ps = ps_q.size(); fs = fd_q.size();
        pulse_start();
        wait_launches(ps + 6, 200);
        @(posedge CLK);            // SETTLE
        @(posedge CLK); #1 abort = 1'b1;   // in WAIT
        @(posedge CLK); #1 abort = 1'b0;
        @(negedge CLK);
        check("abort.busy",  64'(busy), 64'd0);
        check("abort.wr_en", 64'(bus.wr_en), 64'd0);
        check("abort.x",     64'(bus.x), 64'd1);
        check("abort.y",     64'(bus.y), 64'd1);
        check("abort.addr",  64'(bus.wr_addr), 64'd5);
        repeat (30) @(negedge CLK);
        check("abort.writes", 64'(w_q.size() - ws), 64'd5);
        check("abort.no_done", 64'(fd_q.size() - fs), 64'd0);

        // frame_start together with abort in IDLE stays idle
        ps = ps_q.size();
        @(posedge CLK); #1 begin frame_start = 1'b1; abort = 1'b1; end
        @(posedge CLK); #1 begin frame_start = 1'b0; abort = 1'b0; end
        @(negedge CLK);
        check("start_abort.busy", 64'(busy), 64'd0);
        repeat (5) @(negedge CLK);
        check("start_abort.no_launch", 64'(ps_q.size() - ps), 64'd0);

        // restart after abort begins at address 0
        n_lat = 1;
        ws = w_q.size(); fs = fd_q.size();
        pulse_start();
        wait_writes(ws + 1, 40);
        if (w_q.size() > ws)
            check("restart.first_addr", 64'(w_q[ws].addr), 64'd0);
        wait_frame(fs, 200);

        // ---- asynchronous reset mid-WAIT ----
        n_lat = 4;
        ps = ps_q.size();
        pulse_start();
        wait_launches(ps + 3, 200);
        @(posedge CLK);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1 check_zero_outputs("midreset");
        RST_N = 1'b1;
        ws = w_q.size();
        repeat (30) @(negedge CLK);
        check("midreset.no_writes", 64'(w_q.size() - ws), 64'd0);
        check("midreset.busy",      64'(busy), 64'd0);
        n_lat = 1;
        fs = fd_q.size();
        pulse_start();
        wait_writes(ws + 1, 40);
        if (w_q.size() > ws) begin
            check("midreset.restart_addr", 64'(w_q[ws].addr), 64'd0);
            check("midreset.restart_data", 64'(w_q[ws].data), 64'd0);
        end
        wait_frame(fs, 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
